// File: rtl/layer4_reader.sv
// Burst reader for the layer4 buffer: streams word_cnt words from base_addr onward through a 2-entry output FIFO.
// Latency: start -> first read issue 1 cycle, issue -> out_valid 2 cycles; one word per cycle when unstalled.
// Backpressure: out_ready low stops issue once FIFO + in-flight reach 2; port-A write hazards stall issue.
module layer4_reader #(
  parameter int DEPTH = 144,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    base_addr,
  input  logic [7:0]    word_cnt,
  output logic          busy,
  output logic          done,
  output logic          sram_oeb,
  output logic          sram_webn,
  output logic [7:0]    sram_b,
  input  logic [DW-1:0] sram_dob,
  input  logic          wr_active,
  input  logic [7:0]    wr_addr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    addr;
  logic [7:0]    cnt;
  logic [7:0]    issued;
  logic          inflight;
  logic [DW-1:0] fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    occ;
  logic [2:0]    pending;
  logic          push, pop, issue, hazard, accept;

  // The read issued last cycle lands in the FIFO this cycle.
  assign push   = inflight;
  assign pop    = (occ != 2'd0) && out_ready;
  assign accept = (state == IDLE) && start;

  // Same word or the other word of the same even/odd pair as the port-A write.
  assign hazard = wr_active && (((wr_addr ^ addr) & 8'hFE) == 8'h00);

  // Slots committed after this cycle's pop; counting the pop keeps the
  // 2-entry FIFO streaming at one word per cycle instead of stalling every other cycle.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = (state == READ) && (issued < cnt) && (pending < 3'd2) && !hazard;

  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == FIN);
  assign sram_oeb  = issue;
  assign sram_webn = 1'b1;
  assign sram_b    = addr;
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: finish draining when the only remaining word is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (word_cnt != 8'd0) ? READ : FIN;
      READ:  if (issued == cnt) state_nxt = DRAIN;
      DRAIN: if (pop && (occ == 2'd1) && !inflight) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address/count tracking and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= 8'd0;
      cnt      <= 8'd0;
      issued   <= 8'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept && (word_cnt != 8'd0)) begin
        addr   <= base_addr;
        cnt    <= word_cnt;
        issued <= 8'd0;
      end else if (issue) begin
        addr   <= (addr == 8'(DEPTH - 1)) ? 8'd0 : addr + 8'd1;
        issued <= issued + 8'd1;
      end
    end
  end

  // 2-entry in-order output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sram_dob;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_layer4_reader.sv
`timescale 1ns/1ps
module tb_layer4_reader;
  localparam int DEPTH = 144;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    base_addr = 8'd0;
  logic [7:0]    word_cnt = 8'd0;
  logic          busy, done, sram_oeb, sram_webn;
  logic [7:0]    sram_b;
  logic [DW-1:0] sram_dob;
  logic          wr_active;
  logic [7:0]    wr_addr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  layer4_reader #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .sram_oeb(sram_oeb), .sram_webn(sram_webn), .sram_b(sram_b),
    .sram_dob(sram_dob), .wr_active(wr_active), .wr_addr(wr_addr),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buffer contents and synchronous read port model.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  always @(posedge clk) sram_dob <= sram_oeb ? mem[sram_b] : {$urandom, $urandom, $urandom, $urandom};

  // Reference model: the burst is just the address sequence and its words.
  logic [7:0]    exp_addr_q [$];
  logic [DW-1:0] exp_dat_q  [$];
  int n_iss, n_acc, last_acc_cyc, first_iss_cyc, first_acc_cyc, done_cnt, exp_words, start_cyc;
  bit chk_tput = 1'b0;
  bit held = 1'b0;
  logic [DW-1:0] held_dat;

  // Consumer / port-A stimulus, driven shortly after each rising edge.
  int rdy_mode = 0, hz_mode = 0, stall_until = 0, hz_until = 0;
  logic [7:0] hz_addr = 8'd0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (cyc >= stall_until);
    endcase
    case (hz_mode)
      0: begin wr_active = 1'b0; wr_addr = 8'd0; end
      1: begin wr_active = ($urandom_range(0, 3) == 0); wr_addr = 8'($urandom_range(0, DEPTH - 1)); end
      default: begin wr_active = (cyc < hz_until); wr_addr = hz_addr; end
    endcase
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (sram_oeb) begin
        chk("webn", DW'(sram_webn), DW'(1));
        chk("hazard", DW'(wr_active && (wr_addr[7:1] == sram_b[7:1])), DW'(0));
        chk("issue_expected", DW'(exp_addr_q.size() > 0), DW'(1));
        if (exp_addr_q.size() > 0) chk("iss_addr", DW'(sram_b), DW'(exp_addr_q.pop_front()));
        if (n_iss == 0) first_iss_cyc = cyc;
        n_iss++;
      end
      if (held) chk("stable", out_data, held_dat);
      if (out_valid && out_ready) begin
        chk("word_expected", DW'(exp_dat_q.size() > 0), DW'(1));
        if (exp_dat_q.size() > 0) chk("data", out_data, exp_dat_q.pop_front());
        if (n_acc == 0) first_acc_cyc = cyc;
        else if (chk_tput) chk("tput", DW'(cyc - last_acc_cyc), DW'(1));
        last_acc_cyc = cyc;
        n_acc++;
      end
      if (sram_oeb) chk("credit", DW'((n_iss - n_acc) <= 2), DW'(1));
      held = out_valid && !out_ready;
      held_dat = out_data;
      if (done) begin
        done_cnt++;
        chk("done_busy", DW'(busy), DW'(0));
        chk("done_cnt", DW'(n_acc), DW'(exp_words));
        if (exp_words > 0) chk("done_lat", DW'(cyc - last_acc_cyc), DW'(1));
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_valid"}, DW'(out_valid), DW'(0));
    chk({tag, "_oeb"}, DW'(sram_oeb), DW'(0));
    chk({tag, "_b"}, DW'(sram_b), DW'(0));
    chk({tag, "_webn"}, DW'(sram_webn), DW'(1));
    chk({tag, "_data"}, out_data, DW'(0));
  endtask

  // Pulse start, loading the model only if the model should expect the burst.
  task automatic start_burst(input int b, input int n, input bit model);
    @(posedge clk); #1;
    if (model) begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(8'((b + i) % DEPTH));
        exp_dat_q.push_back(mem[(b + i) % DEPTH]);
      end
      n_iss = 0; n_acc = 0; done_cnt = 0; exp_words = n; start_cyc = cyc;
      stall_until = cyc + 6;
      hz_until = cyc + 4;
    end
    base_addr = 8'(b);
    word_cnt = 8'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", DW'(got), DW'(1));
    @(posedge clk); #1;
    chk("leftover_words", DW'(exp_dat_q.size()), DW'(0));
    chk("done_once", DW'(done_cnt), DW'(1));
  endtask

  task automatic run_burst(input int b, input int n, input int budget);
    start_burst(b, n, 1'b1);
    if (n > 0) begin
      @(negedge clk);
      chk("busy_after_start", DW'(busy), DW'(1));
    end
    wait_done(budget);
  endtask

  initial begin
    int iss_snap;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming burst at full rate.
    rdy_mode = 0; hz_mode = 0; chk_tput = 1'b1;
    run_burst(0, 4, 40);
    chk("first_acc_lat", DW'(first_acc_cyc - start_cyc), DW'(3));
    chk_tput = 1'b0;

    // Address wrap.
    run_burst(142, 4, 40);

    // Consumer stalled for 6 cycles.
    rdy_mode = 2;
    run_burst(7, 5, 60);
    rdy_mode = 0;

    // Port-A write on the 2/3 pair for the first three READ cycles.
    hz_mode = 2; hz_addr = 8'd3;
    run_burst(2, 4, 60);
    chk("hz_first_iss", DW'(first_iss_cyc - start_cyc), DW'(4));
    hz_mode = 0;

    // Zero-length burst.
    start_burst(5, 0, 1'b1);
    @(negedge clk);
    chk("zero_done", DW'(done), DW'(1));
    @(negedge clk);
    chk("zero_done_pulse", DW'(done), DW'(0));
    chk("zero_no_iss", DW'(n_iss), DW'(0));

    // Start while busy is ignored.
    start_burst(10, 6, 1'b1);
    start_burst(50, 3, 1'b0);
    wait_done(60);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_start", DW'(n_iss), DW'(6));

    // Reset in the third cycle of a burst.
    start_burst(20, 8, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr_q.delete();
    exp_dat_q.delete();
    @(negedge clk);
    check_reset("rst_mid");
    iss_snap = n_iss;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_done", DW'(done_cnt), DW'(0));
    chk("rst_no_iss", DW'(n_iss), DW'(iss_snap));
    run_burst(30, 8, 60);

    // Randomized bursts with random backpressure and write hazards.
    rdy_mode = 1; hz_mode = 1;
    for (int k = 0; k < 20; k++) begin
      int b, n;
      b = $urandom_range(0, DEPTH - 1);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH) : $urandom_range(1, 12);
      run_burst(b, n, 20 * n + 50);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
